// File: rtl/orv64_mul_arb.sv
// rtl/orv64_mul_arb.sv - round-robin arbiter sharing one iterative 64x64 multiplier
// Optional feature macro: ORV64_MUL_ARB_FAST_ZERO_EN (zero operand skips the multiplier)
package orv64_mul_arb_pkg;
  typedef enum logic [2:0] {
    ORV64_MUL_TYPE_L   = 3'd0,
    ORV64_MUL_TYPE_HSS = 3'd1,
    ORV64_MUL_TYPE_HUU = 3'd2,
    ORV64_MUL_TYPE_HSU = 3'd3,
    ORV64_MUL_TYPE_W   = 3'd4
  } orv64_mul_type_t;
endpackage

module orv64_mul_arb
  import orv64_mul_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int MAX_CYC = 80
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ-1:0][63:0]       req_rs1,
  input  logic [NUM_REQ-1:0][63:0]       req_rs2,
  input  orv64_mul_type_t [NUM_REQ-1:0]  req_type,
  input  logic [NUM_REQ-1:0]             req_hi,
  input  logic [NUM_REQ-1:0]             req_kill,
  output logic [NUM_REQ-1:0]             resp_valid,
  input  logic [NUM_REQ-1:0]             resp_ready,
  output logic [63:0]                    resp_data,
  output logic                           resp_err,
  output logic [63:0]                    mul_rs1,
  output logic [63:0]                    mul_rs2,
  output orv64_mul_type_t                mul_type,
  output logic                           mul_start,
  input  logic                           mul_complete,
  input  logic [63:0]                    mul_rdh,
  input  logic [63:0]                    mul_rdl,
  output logic                           busy
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CYC_W = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_RESP  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  state_t           state;
  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] owner;
  logic [CYC_W-1:0] cyc;
  logic             hi_q;
  logic             kill_pend;
  logic [PTR_W-1:0] grant_idx;
  logic             grant_vld;
  logic [PTR_W-1:0] rr_next;
  logic             owner_kill;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [PTR_W-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

  // Scan downward so the requester closest to rr_ptr is the last writer and wins.
  always_comb begin
    int pos;
    pos       = 0;
    grant_idx = '0;
    grant_vld = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      pos = int'(rr_ptr) + i;
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
      if (req_valid[pos]) begin
        grant_idx = PTR_W'(pos);
        grant_vld = 1'b1;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == ST_IDLE && grant_vld) req_ready = onehot(grant_idx);
  end

  assign rr_next    = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + PTR_W'(1);
  assign owner_kill = kill_pend | req_kill[owner];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      rr_ptr     <= '0;
      owner      <= '0;
      cyc        <= '0;
      hi_q       <= 1'b0;
      kill_pend  <= 1'b0;
      mul_rs1    <= '0;
      mul_rs2    <= '0;
      mul_type   <= ORV64_MUL_TYPE_L;
      mul_start  <= 1'b0;
      resp_valid <= '0;
      resp_data  <= '0;
      resp_err   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_vld) begin
            mul_rs1   <= req_rs1[grant_idx];
            mul_rs2   <= req_rs2[grant_idx];
            mul_type  <= req_type[grant_idx];
            hi_q      <= req_hi[grant_idx];
            kill_pend <= req_kill[grant_idx];
            owner     <= grant_idx;
            rr_ptr    <= rr_next;
            cyc       <= '0;
            busy      <= 1'b1;
`ifdef ORV64_MUL_ARB_FAST_ZERO_EN
            if (req_rs1[grant_idx] == 64'd0 || req_rs2[grant_idx] == 64'd0) begin
              resp_data  <= '0;
              resp_err   <= 1'b0;
              resp_valid <= onehot(grant_idx);
              state      <= ST_RESP;
            end else begin
              mul_start <= 1'b1;
              state     <= ST_RUN;
            end
`else
            mul_start <= 1'b1;
            state     <= ST_RUN;
`endif
          end
        end
        ST_RUN: begin
          cyc <= cyc + CYC_W'(1);
          // A kill outranks a completion or timeout landing in the same cycle.
          if (owner_kill) begin
            kill_pend <= 1'b0;
            mul_start <= 1'b0;
            state     <= ST_DRAIN;
          end else if (mul_complete) begin
            resp_data  <= hi_q ? mul_rdh : mul_rdl;
            resp_err   <= 1'b0;
            resp_valid <= onehot(owner);
            mul_start  <= 1'b0;
            state      <= ST_RESP;
          end else if (cyc == CYC_W'(MAX_CYC - 1)) begin
            resp_data  <= '0;
            resp_err   <= 1'b1;
            resp_valid <= onehot(owner);
            mul_start  <= 1'b0;
            state      <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (owner_kill || resp_ready[owner]) begin
            kill_pend  <= 1'b0;
            resp_err   <= 1'b0;
            resp_valid <= '0;
            busy       <= 1'b0;
            state      <= ST_IDLE;
          end
        end
        ST_DRAIN: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          mul_start  <= 1'b0;
          resp_valid <= '0;
          busy       <= 1'b0;
          state      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_orv64_mul_arb.sv
// tb/tb_orv64_mul_arb.sv - scoreboard bench for orv64_mul_arb driving a behavioural multiplier
module tb_orv64_mul_arb;
  import orv64_mul_arb_pkg::*;

  localparam int NUM_REQ = 2;
  localparam int MAX_CYC = 16;
  localparam int MUL_LAT = 6;

  logic                          clk = 1'b0;
  logic                          rst_n;
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0][63:0]      req_rs1;
  logic [NUM_REQ-1:0][63:0]      req_rs2;
  orv64_mul_type_t [NUM_REQ-1:0] req_type;
  logic [NUM_REQ-1:0]            req_hi;
  logic [NUM_REQ-1:0]            req_kill;
  logic [NUM_REQ-1:0]            resp_valid;
  logic [NUM_REQ-1:0]            resp_ready;
  logic [63:0]                   resp_data;
  logic                          resp_err;
  logic [63:0]                   mul_rs1;
  logic [63:0]                   mul_rs2;
  orv64_mul_type_t               mul_type;
  logic                          mul_start;
  logic                          mul_complete;
  logic [63:0]                   mul_rdh;
  logic [63:0]                   mul_rdl;
  logic                          busy;

  always #5 clk = ~clk;

  orv64_mul_arb #(.NUM_REQ(NUM_REQ), .MAX_CYC(MAX_CYC)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_type(req_type),
    .req_hi(req_hi), .req_kill(req_kill),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_err(resp_err),
    .mul_rs1(mul_rs1), .mul_rs2(mul_rs2), .mul_type(mul_type),
    .mul_start(mul_start), .mul_complete(mul_complete),
    .mul_rdh(mul_rdh), .mul_rdl(mul_rdl), .busy(busy)
  );

  // Multiplier stand-in: completes on the MUL_LAT-th cycle of mul_start, counter clears when start drops.
  logic [7:0] mcnt;
  logic       stall_mul;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         mcnt <= '0;
    else if (mul_start) mcnt <= mcnt + 8'd1;
    else                mcnt <= '0;
  end
  assign mul_complete = mul_start && !stall_mul && (mcnt == 8'(MUL_LAT - 1));

  logic [127:0] prod;
  logic [63:0]  wprod;
  always_comb begin
    prod  = '0;
    wprod = {32'b0, mul_rs1[31:0]} * {32'b0, mul_rs2[31:0]};
    case (mul_type)
      ORV64_MUL_TYPE_HSS: prod = {{64{mul_rs1[63]}}, mul_rs1} * {{64{mul_rs2[63]}}, mul_rs2};
      ORV64_MUL_TYPE_HSU: prod = {{64{mul_rs1[63]}}, mul_rs1} * {64'b0, mul_rs2};
      ORV64_MUL_TYPE_W:   prod = {{96{wprod[31]}}, wprod[31:0]};
      default:            prod = {64'b0, mul_rs1} * {64'b0, mul_rs2};
    endcase
  end
  assign mul_rdh = prod[127:64];
  assign mul_rdl = prod[63:0];

  typedef struct {
    int          owner;
    logic [63:0] data;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic push_exp(input int o, input logic [63:0] d, input logic e);
    exp_t x;
    x.owner = o;
    x.data  = d;
    x.err   = e;
    exp_q.push_back(x);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && |(resp_valid & resp_ready & ~req_kill)) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_resp", 64'(resp_valid), 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("resp_owner", 64'(resp_valid), 64'd1 << e.owner);
        chk("resp_data", resp_data, e.data);
        chk("resp_err", 64'(resp_err), 64'(e.err));
      end
    end
  end

  task automatic do_reset();
    rst_n      = 1'b0;
    req_valid  = '0;
    req_kill   = '0;
    resp_ready = '1;
    stall_mul  = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic issue(input int idx, input logic [63:0] a, input logic [63:0] b,
                       input orv64_mul_type_t t, input logic hi);
    bit got;
    got            = 1'b0;
    req_rs1[idx]   = a;
    req_rs2[idx]   = b;
    req_type[idx]  = t;
    req_hi[idx]    = hi;
    req_valid[idx] = 1'b1;
    for (int n = 0; n < 100; n++) begin
      #1;
      if (req_ready[idx]) begin
        got = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!got) chk("grant_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1 req_valid[idx] = 1'b0;
  endtask

  // Latency counted in cycles from the accept cycle to the first cycle resp_valid is seen.
  task automatic measure(input int idx, output int lat, output int hi_cnt);
    lat    = 1;
    hi_cnt = 0;
    while (!resp_valid[idx] && lat < 200) begin
      if (mul_start) hi_cnt++;
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || exp_q.size() != 0) && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 300) chk("idle_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          lat;
    int          hic;
    logic [63:0] held;
    bit          hold_ok;
    req_rs1 = '0;
    req_rs2 = '0;
    req_hi  = '0;
    for (int i = 0; i < NUM_REQ; i++) req_type[i] = ORV64_MUL_TYPE_L;
    rst_n      = 1'b0;
    req_valid  = '0;
    req_kill   = '0;
    resp_ready = '1;
    stall_mul  = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_mul_start", 64'(mul_start), 64'd0);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_resp_data", resp_data, 64'd0);
    chk("rst_resp_err", 64'(resp_err), 64'd0);
    do_reset();

    // 1: simple MUL, low half
    push_exp(0, 64'd15, 1'b0);
    issue(0, 64'd3, 64'd5, ORV64_MUL_TYPE_L, 1'b0);
    measure(0, lat, hic);
    chk("t1_latency", 64'(lat), 64'(MUL_LAT + 1));
    chk("t1_start_cycles", 64'(hic), 64'(MUL_LAT));
    chk("t1_start_low_resp", 64'(mul_start), 64'd0);
    wait_idle();

    // 2: both requesters from reset, HSS high half of -2*3
    do_reset();
    push_exp(0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    push_exp(1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    for (int i = 0; i < NUM_REQ; i++) begin
      req_rs1[i]  = 64'hFFFF_FFFF_FFFF_FFFE;
      req_rs2[i]  = 64'd3;
      req_type[i] = ORV64_MUL_TYPE_HSS;
      req_hi[i]   = 1'b1;
    end
    req_valid = 2'b11;
    #1 chk("t2_first_grant", 64'(req_ready), 64'd1);
    @(posedge clk);
    #1 req_valid[0] = 1'b0;
    #1 chk("t2_req1_waits", 64'(req_ready), 64'd0);
    issue(1, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3, ORV64_MUL_TYPE_HSS, 1'b1);
    wait_idle();

    // 3: kill owner in RUN cycle 5, pending req1 granted after one drain cycle
    issue(0, 64'd7, 64'd9, ORV64_MUL_TYPE_L, 1'b0);
    req_rs1[1]   = 64'd4;
    req_rs2[1]   = 64'd6;
    req_type[1]  = ORV64_MUL_TYPE_L;
    req_hi[1]    = 1'b0;
    req_valid[1] = 1'b1;
    push_exp(1, 64'd24, 1'b0);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    chk("t3_still_run", 64'(mul_start), 64'd1);
    req_kill[0] = 1'b1;
    @(posedge clk);
    #1 req_kill[0] = 1'b0;
    chk("t3_drain_start", 64'(mul_start), 64'd0);
    chk("t3_drain_noresp", 64'(resp_valid), 64'd0);
    chk("t3_drain_ready", 64'(req_ready), 64'd0);
    chk("t3_drain_busy", 64'(busy), 64'd1);
    @(posedge clk);
    #1 chk("t3_regrant", 64'(req_ready), 64'd2);
    chk("t3_idle_start", 64'(mul_start), 64'd0);
    @(posedge clk);
    #1 req_valid[1] = 1'b0;
    wait_idle();

    // 4: multiplier never completes -> timeout error, then a clean op
    stall_mul = 1'b1;
    push_exp(0, 64'd0, 1'b1);
    issue(0, 64'd11, 64'd13, ORV64_MUL_TYPE_L, 1'b0);
    measure(0, lat, hic);
    chk("t4_latency", 64'(lat), 64'(MAX_CYC + 1));
    chk("t4_start_cycles", 64'(hic), 64'(MAX_CYC));
    @(posedge clk);
    #1 stall_mul = 1'b0;
    chk("t4_err_cleared", 64'(resp_err), 64'd0);
    push_exp(0, 64'd12, 1'b0);
    issue(0, 64'd3, 64'd4, ORV64_MUL_TYPE_L, 1'b0);
    wait_idle();

    // 5: response back-pressure holds data and blocks req1
    resp_ready[0] = 1'b0;
    push_exp(0, 64'd42, 1'b0);
    issue(0, 64'd6, 64'd7, ORV64_MUL_TYPE_L, 1'b0);
    req_rs1[1]   = 64'd2;
    req_rs2[1]   = 64'd5;
    req_type[1]  = ORV64_MUL_TYPE_L;
    req_hi[1]    = 1'b0;
    req_valid[1] = 1'b1;
    push_exp(1, 64'd10, 1'b0);
    measure(0, lat, hic);
    held    = resp_data;
    hold_ok = 1'b1;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (resp_data !== held || resp_valid !== 2'b01 || req_ready !== 2'b00) hold_ok = 1'b0;
    end
    chk("t5_hold", 64'(hold_ok), 64'd1);
    chk("t5_held_data", held, 64'd42);
    resp_ready[0] = 1'b1;
    @(posedge clk);
    #1 chk("t5_regrant", 64'(req_ready), 64'd2);
    @(posedge clk);
    #1 req_valid[1] = 1'b0;
    wait_idle();

    // 8: kill and resp_ready together in RESP -> response dropped
    resp_ready[0] = 1'b0;
    issue(0, 64'd2, 64'd2, ORV64_MUL_TYPE_L, 1'b0);
    measure(0, lat, hic);
    chk("t8_resp_data", resp_data, 64'd4);
    req_kill[0]   = 1'b1;
    resp_ready[0] = 1'b1;
    @(posedge clk);
    #1 req_kill[0] = 1'b0;
    chk("t8_dropped", 64'(resp_valid), 64'd0);
    chk("t8_idle", 64'(busy), 64'd0);

    // 7: asynchronous reset mid-operation
    issue(0, 64'd9, 64'd9, ORV64_MUL_TYPE_L, 1'b0);
    @(posedge clk);
    #1 chk("t7_running", 64'(mul_start), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("t7_busy", 64'(busy), 64'd0);
    chk("t7_mul_start", 64'(mul_start), 64'd0);
    chk("t7_resp_data", resp_data, 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // 6: zero operand
    push_exp(0, 64'd0, 1'b0);
    issue(0, 64'd5, 64'd0, ORV64_MUL_TYPE_L, 1'b0);
    measure(0, lat, hic);
`ifdef ORV64_MUL_ARB_FAST_ZERO_EN
    chk("t6_latency", 64'(lat), 64'd1);
    chk("t6_start_cycles", 64'(hic), 64'd0);
`else
    chk("t6_latency", 64'(lat), 64'(MUL_LAT + 1));
    chk("t6_start_cycles", 64'(hic), 64'(MUL_LAT));
`endif
    wait_idle();

    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
